aes_frame_packer: RTL and testbench

AES_FRAME_PACKER -- requirements
Module: aes_frame_packer

---
 rtl/aes_ctrl_pkg.sv | 22 ++
 rtl/byte_timeout.sv | 29 ++
 rtl/aes_frame_packer.sv | 149 ++++++++++++++
 tb/tb_aes_frame_packer.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ctrl_pkg.sv
// Shared definitions for the AES control path: command codes, sync byte default
// and the frame packer FSM encoding.
package aes_ctrl_pkg;

   localparam logic [7:0] SYNC_DEFAULT = 8'hA5;

   localparam logic [7:0] CMD_ENCRYPT  = 8'h01;
   localparam logic [7:0] CMD_DECRYPT  = 8'h02;
   localparam logic [7:0] CMD_KEY_LOAD = 8'h03;

   typedef enum logic [1:0] {
      StHunt = 2'd0,
      StCmd  = 2'd1,
      StData = 2'd2,
      StPush = 2'd3
   } packer_state_e;

   function automatic logic is_legal_cmd(input logic [7:0] cmd);
      return (cmd == CMD_ENCRYPT) || (cmd == CMD_DECRYPT) || (cmd == CMD_KEY_LOAD);
   endfunction

endpackage

// File: rtl/byte_timeout.sv
// Inter-byte idle counter; expire is asserted while enabled and the count sits at TIMEOUT-1.
module byte_timeout #(
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic wr_clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic expire
);

   localparam int unsigned CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_cnt;

   assign expire = enable && (r_cnt == LAST);

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (clear) begin
         r_cnt <= '0;
      end else if (enable && !expire) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

endmodule

// File: rtl/aes_frame_packer.sv
// Collects SYNC/cmd/16-byte host frames and pushes them as five 32-bit words
// (header plus payload) into the downstream async FIFO.
module aes_frame_packer
   import aes_ctrl_pkg::*;
#(
   parameter logic [7:0]  SYNC    = SYNC_DEFAULT,
   parameter int unsigned TIMEOUT = 1024
) (
   input  logic        wr_clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [7:0]  in_data,
   output logic        in_ready,
   input  logic        wfull,
   output logic        wr_en,
   output logic [31:0] din,
   output logic        frame_err,
   output logic [7:0]  err_cnt,
   output logic        busy
);

   packer_state_e r_state, w_state_d;

   logic [7:0]   r_cmd;
   logic [7:0]   r_seq;
   logic [7:0]   r_err_cnt;
   logic [127:0] r_buf;
   logic [3:0]   r_bidx;
   logic [2:0]   r_widx;
   logic         r_frame_err;

   logic w_accept;
   logic w_in_frame;
   logic w_expire;
   logic w_drop;

   assign in_ready   = (r_state != StPush);
   assign busy       = (r_state != StHunt);
   assign wr_en      = (r_state == StPush) && !wfull;
   assign frame_err  = r_frame_err;
   assign err_cnt    = r_err_cnt;
   assign w_accept   = in_valid && in_ready;
   assign w_in_frame = (r_state == StCmd) || (r_state == StData);

   // Held clear outside CMD/DATA so every frame starts with a fresh count.
   byte_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_byte_timeout (
      .wr_clk (wr_clk),
      .rst_n  (rst_n),
      .clear  (w_accept || !w_in_frame),
      .enable (w_in_frame),
      .expire (w_expire)
   );

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StHunt;
      end else begin
         r_state <= w_state_d;
      end
   end

   // An accepted byte always wins over a timeout expiring in the same cycle.
   always_comb begin
      w_state_d = r_state;
      w_drop    = 1'b0;
      unique case (r_state)
         StHunt: begin
            if (w_accept && (in_data == SYNC)) w_state_d = StCmd;
         end
         StCmd: begin
            if (w_accept) begin
               if (is_legal_cmd(in_data)) begin
                  w_state_d = StData;
               end else begin
                  w_drop    = 1'b1;
                  w_state_d = StHunt;
               end
            end else if (w_expire) begin
               w_drop    = 1'b1;
               w_state_d = StHunt;
            end
         end
         StData: begin
            if (w_accept) begin
               if (r_bidx == 4'd15) w_state_d = StPush;
            end else if (w_expire) begin
               w_drop    = 1'b1;
               w_state_d = StHunt;
            end
         end
         StPush: begin
            if (wr_en && (r_widx == 3'd4)) w_state_d = StHunt;
         end
         default: w_state_d = StHunt;
      endcase
   end

   always_ff @(posedge wr_clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cmd       <= '0;
         r_seq       <= '0;
         r_err_cnt   <= '0;
         r_buf       <= '0;
         r_bidx      <= '0;
         r_widx      <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_frame_err <= w_drop;
         if (w_drop) begin
            r_buf  <= '0;
            r_bidx <= '0;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
         end
         if ((r_state == StCmd) && w_accept) begin
            r_cmd  <= in_data;
            r_bidx <= '0;
         end
         // Shift-in leaves the first payload byte at [127:120] after 16 bytes.
         if ((r_state == StData) && w_accept) begin
            r_buf  <= {r_buf[119:0], in_data};
            r_bidx <= r_bidx + 4'd1;
            r_widx <= '0;
         end
         if (wr_en) begin
            if (r_widx == 3'd4) begin
               r_widx <= '0;
               r_seq  <= r_seq + 8'd1;
            end else begin
               r_widx <= r_widx + 3'd1;
            end
         end
      end
   end

   always_comb begin
      din = '0;
      case (r_widx)
         3'd0:    din = {SYNC, r_cmd, 8'h00, r_seq};
         3'd1:    din = r_buf[127:96];
         3'd2:    din = r_buf[95:64];
         3'd3:    din = r_buf[63:32];
         3'd4:    din = r_buf[31:0];
         default: din = '0;
      endcase
   end

endmodule

// File: tb/tb_aes_frame_packer.sv
// Directed self-checking bench for aes_frame_packer (short TIMEOUT to keep runs brief).
module tb_aes_frame_packer;

   localparam int unsigned TO = 16;

   logic        wr_clk;
   logic        rst_n;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wfull;
   logic        wr_en;
   logic [31:0] din;
   logic        frame_err;
   logic [7:0]  err_cnt;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   int n_ferr  = 0;
   int rdy_lo;
   logic [31:0] wq[$];

   aes_frame_packer #(
      .SYNC    (8'hA5),
      .TIMEOUT (TO)
   ) dut (
      .wr_clk    (wr_clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .wfull     (wfull),
      .wr_en     (wr_en),
      .din       (din),
      .frame_err (frame_err),
      .err_cnt   (err_cnt),
      .busy      (busy)
   );

   initial wr_clk = 1'b0;
   always #5 wr_clk = ~wr_clk;

   // A write happens on the rising edge following a negedge with wr_en high.
   always @(negedge wr_clk) begin
      if (wr_en) wq.push_back(din);
      if (frame_err) n_ferr++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] word_at(input int k);
      if (k < wq.size()) return wq[k];
      return 32'hDEADBEEF;
   endfunction

   task automatic tick();
      @(posedge wr_clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      in_valid = 1'b1;
      in_data  = b;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] cmd, input logic [7:0] base);
      send(8'hA5);
      send(cmd);
      for (int i = 0; i < 16; i++) send(base + 8'(i));
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   initial begin
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_data  = 8'h00;
      wfull    = 1'b0;
      idle(2);
      @(negedge wr_clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_wr_en", wr_en, 0);
      check("rst_busy", busy, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_err_cnt", err_cnt, 0);
      tick();
      rst_n = 1'b1;
      idle(2);

      // Basic frame, no backpressure
      wq.delete();
      send_frame(8'h01, 8'h00);
      rdy_lo = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge wr_clk);
         if (!in_ready) rdy_lo++;
         tick();
      end
      check("a_ready_low_cycles", rdy_lo, 5);
      check("a_nwrites", wq.size(), 5);
      check("a_w0", word_at(0), 32'hA5010000);
      check("a_w1", word_at(1), 32'h00010203);
      check("a_w2", word_at(2), 32'h04050607);
      check("a_w3", word_at(3), 32'h08090A0B);
      check("a_w4", word_at(4), 32'h0C0D0E0F);
      check("a_busy_after", busy, 0);

      // Same frame with a 3-cycle FIFO stall on word 2
      wq.delete();
      send_frame(8'h01, 8'h00);
      rdy_lo = 0;
      for (int c = 0; c < 12; c++) begin
         wfull = (c >= 2) && (c <= 4);
         @(negedge wr_clk);
         if (!in_ready) rdy_lo++;
         if (wfull) begin
            check("b_stall_wr_en", wr_en, 0);
            check("b_stall_din", din, 32'h04050607);
         end
         tick();
      end
      wfull = 1'b0;
      check("b_ready_low_cycles", rdy_lo, 8);
      check("b_nwrites", wq.size(), 5);
      check("b_w0", word_at(0), 32'hA5010001);
      check("b_w2", word_at(2), 32'h04050607);
      check("b_w3", word_at(3), 32'h08090A0B);
      check("b_w4", word_at(4), 32'h0C0D0E0F);

      // Illegal command
      wq.delete();
      n_ferr = 0;
      send(8'hA5);
      send(8'h07);
      idle(3);
      check("c_ferr_pulses", n_ferr, 1);
      check("c_err_cnt", err_cnt, 1);
      check("c_nwrites", wq.size(), 0);
      check("c_busy", busy, 0);
      send_frame(8'h03, 8'h10);
      idle(8);
      check("c_next_nwrites", wq.size(), 5);
      check("c_next_hdr", word_at(0), 32'hA5030002);
      check("c_next_w1", word_at(1), 32'h10111213);

      // Timeout mid-payload
      wq.delete();
      n_ferr = 0;
      send(8'hA5);
      send(8'h02);
      for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
      idle(TO + 4);
      check("d_ferr_pulses", n_ferr, 1);
      check("d_err_cnt", err_cnt, 2);
      check("d_busy", busy, 0);
      check("d_nwrites", wq.size(), 0);

      // Byte on the expiry cycle wins over the timeout
      send(8'hA5);
      send(8'h02);
      for (int i = 0; i < 8; i++) send(8'h20 + 8'(i));
      idle(TO - 1);
      for (int i = 8; i < 16; i++) send(8'h20 + 8'(i));
      idle(8);
      check("e_ferr_pulses", n_ferr, 1);
      check("e_err_cnt", err_cnt, 2);
      check("e_nwrites", wq.size(), 5);
      check("e_hdr", word_at(0), 32'hA5020003);
      check("e_w1", word_at(1), 32'h20212223);
      check("e_w4", word_at(4), 32'h2C2D2E2F);

      // Junk before sync is ignored
      wq.delete();
      n_ferr = 0;
      send(8'h00);
      send(8'hFF);
      send_frame(8'h03, 8'h30);
      idle(8);
      check("f_ferr_pulses", n_ferr, 0);
      check("f_nwrites", wq.size(), 5);
      check("f_hdr", word_at(0), 32'hA5030004);
      check("f_w2", word_at(2), 32'h34353637);

      // Reset during PUSH word 2
      wq.delete();
      send_frame(8'h01, 8'h40);
      idle(2);
      rst_n = 1'b0;
      #1;
      check("g_rst_wr_en", wr_en, 0);
      check("g_rst_in_ready", in_ready, 1);
      check("g_rst_busy", busy, 0);
      idle(2);
      check("g_nwrites_before_rst", wq.size(), 2);
      check("g_w1", word_at(1), 32'h40414243);
      rst_n = 1'b1;
      idle(1);
      check("g_err_cnt", err_cnt, 0);
      wq.delete();
      send_frame(8'h01, 8'h50);
      idle(8);
      check("g_hdr_seq0", word_at(0), 32'hA5010000);
      check("g_nwrites_after", wq.size(), 5);

      // err_cnt saturation
      wq.delete();
      for (int i = 0; i < 260; i++) begin
         send(8'hA5);
         send(8'h00);
      end
      idle(2);
      check("h_err_sat", err_cnt, 8'hFF);
      check("h_nwrites", wq.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
